// File: rtl/wormhole_n_to_1_arbiter_pkg.sv
// Shared flit format, flit-type encodings and arbiter state for the wormhole concentrator.
// Pure declarations: no latency, no flow control.
package wormhole_n_to_1_arbiter_pkg;

   localparam int FLIT_SIZE  = 16;
   localparam int HEADER_LEN = 2;

   typedef logic [FLIT_SIZE-1:0]  flit_t;
   typedef logic [HEADER_LEN-1:0] flit_type_t;

   localparam flit_type_t HEAD_FLIT   = 2'b00;
   localparam flit_type_t BODY_FLIT   = 2'b01;
   localparam flit_type_t TAIL_FLIT   = 2'b10;
   localparam flit_type_t SINGLE_FLIT = 2'b11;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } arb_state_e;

   function automatic flit_type_t flit_type(flit_t f);
      return f[FLIT_SIZE-1 -: HEADER_LEN];
   endfunction

   function automatic logic starts_packet(flit_type_t t);
      return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
   endfunction

   function automatic logic continues_packet(flit_type_t t);
      return (t == BODY_FLIT) || (t == TAIL_FLIT);
   endfunction

   // (base + k) mod n for base < n and k < n, without a divider.
   function automatic int rr_wrap(int base, int k, int n);
      int s;
      s = base + k;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/wormhole_n_to_1_arbiter_if.sv
// Flit bus of the N-to-1 concentrator: N valid/avail input channels, one valid/avail output.
// Signal names follow the router datapath so the block drops in for the single-slot reductor.
interface wormhole_n_to_1_arbiter_if #(
   parameter int N = 8
);
   import wormhole_n_to_1_arbiter_pkg::*;

   localparam int SEL_W = $clog2(N);

   logic [FLIT_SIZE*N-1:0] in;
   logic [N-1:0]           in_valid;
   logic [N-1:0]           in_avail;
   logic [FLIT_SIZE-1:0]   out;
   logic                   out_valid;
   logic                   out_avail;
   logic [SEL_W-1:0]       out_src;
   logic                   drop_err;

   modport master (
      output in, in_valid, out_avail,
      input  in_avail, out, out_valid, out_src, drop_err
   );

   modport slave (
      input  in, in_valid, out_avail,
      output in_avail, out, out_valid, out_src, drop_err
   );

endinterface

// File: rtl/wormhole_n_to_1_arbiter_flit_fifo.sv
// Per-channel flit FIFO; pushed flit visible at head next cycle, full refuses push even while popping.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module flit_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/wormhole_n_to_1_arbiter.sv
// Packet-aware N:1 flit concentrator: per-input FIFOs, round-robin grant held HEAD..TAIL, orphan drop.
// One cycle in-to-out; output is combinational from FIFO heads and holds while out_avail is low.
module wormhole_n_to_1_arbiter
   import wormhole_n_to_1_arbiter_pkg::*;
#(
   parameter int N     = 8,
   parameter int DEPTH = 4
) (
   input logic                      clk,
   input logic                      rst,
   wormhole_n_to_1_arbiter_if.slave bus
);
   localparam int SEL_W = $clog2(N);

   arb_state_e       state_q, state_d;
   logic [SEL_W-1:0] owner_q, owner_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [N-1:0]     push, pop, full, empty, eligible, orphan;
   flit_t            head [N];

   logic             rr_found;
   logic [SEL_W-1:0] rr_sel, rr_idx;
   logic             drop_found;
   logic [SEL_W-1:0] drop_idx;
   logic [SEL_W-1:0] sel;
   logic             out_vld, xfer;
   flit_type_t       sel_type;

   assign bus.in_avail = rst ? '0 : ~full;
   assign push         = bus.in_valid & bus.in_avail;

   for (genvar i = 0; i < N; i++) begin : g_ch
      flit_fifo #(
         .WIDTH (FLIT_SIZE),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[i]),
         .din   (bus.in[FLIT_SIZE*i +: FLIT_SIZE]),
         .pop   (pop[i]),
         .full  (full[i]),
         .empty (empty[i]),
         .head  (head[i])
      );

      assign eligible[i] = !empty[i] && starts_packet(flit_type(head[i]));
      // The owner's BODY/TAIL flits are the packet in flight, never orphans.
      assign orphan[i]   = !empty[i] && continues_packet(flit_type(head[i]))
                           && !((state_q == LOCKED) && (owner_q == SEL_W'(i)));
   end

   always_comb begin
      rr_found = 1'b0;
      rr_sel   = '0;
      rr_idx   = '0;
      for (int k = 0; k < N; k++) begin
         rr_idx = SEL_W'(rr_wrap(int'(rr_ptr_q), k, N));
         if (!rr_found && eligible[rr_idx]) begin
            rr_found = 1'b1;
            rr_sel   = rr_idx;
         end
      end
   end

   always_comb begin
      drop_found = 1'b0;
      drop_idx   = '0;
      for (int j = 0; j < N; j++) begin
         if (!drop_found && orphan[j]) begin
            drop_found = 1'b1;
            drop_idx   = SEL_W'(j);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      sel      = '0;
      out_vld  = 1'b0;
      unique case (state_q)
         UNLOCKED: begin
            sel     = rr_sel;
            out_vld = rr_found;
         end
         LOCKED: begin
            sel     = owner_q;
            out_vld = !empty[owner_q];
         end
      endcase
      out_vld  = out_vld && !rst;
      xfer     = out_vld && bus.out_avail;
      sel_type = flit_type(head[sel]);

      // A stray HEAD/SINGLE at the owner closes the packet exactly like a TAIL.
      if (xfer) begin
         unique case (state_q)
            UNLOCKED: begin
               if (sel_type == HEAD_FLIT) begin
                  state_d = LOCKED;
                  owner_d = sel;
               end else begin
                  rr_ptr_d = SEL_W'(rr_wrap(int'(sel), 1, N));
               end
            end
            LOCKED: begin
               if (sel_type != BODY_FLIT) begin
                  state_d  = UNLOCKED;
                  rr_ptr_d = SEL_W'(rr_wrap(int'(owner_q), 1, N));
               end
            end
         endcase
      end
   end

   always_comb begin
      pop = '0;
      if (xfer)       pop[sel]      = 1'b1;
      if (drop_found) pop[drop_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= UNLOCKED;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.out_valid = out_vld;
   assign bus.out       = out_vld ? head[sel] : '0;
   assign bus.out_src   = out_vld ? sel : '0;
   assign bus.drop_err  = drop_found && !rst;

endmodule

// File: tb/tb_wormhole_n_to_1_arbiter.sv
// Bench for the wormhole concentrator: vector table, directed corner sequences, random vs queue model.
module tb_wormhole_n_to_1_arbiter;
   import wormhole_n_to_1_arbiter_pkg::*;

   localparam int N     = 8;
   localparam int DEPTH = 4;
   localparam int PW    = FLIT_SIZE - HEADER_LEN;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wormhole_n_to_1_arbiter_if #(.N(N)) bus ();

   wormhole_n_to_1_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [N-1:0] vmask;
      flit_type_t   typ;
      logic [13:0]  base;
      logic         oav;
      logic         evld;
      logic [2:0]   esrc;
      flit_t        eout;
      logic         edrop;
   } vec_t;

   int    checks   = 0;
   int    failures = 0;
   vec_t  tbl [9];
   flit_t got_f [$];
   int    got_s [$];
   flit_t pkt [6];
   int    ptr;

   flit_t        mq [N][$];
   bit           mlock;
   int           mown, mrr;
   flit_t        gf [N];
   int           grem [N];
   logic [N-1:0] ex_av, v;
   logic         ex_vld, ex_drop, oav;
   int           ex_src, ex_didx;
   flit_t        ex_out, f;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic flit_t mk(flit_type_t t, int p);
      return {t, PW'(p)};
   endfunction

   function automatic flit_type_t ftype(flit_t x);
      return x[FLIT_SIZE-1 -: HEADER_LEN];
   endfunction

   task automatic set_ch(int i, flit_t x);
      bus.in[FLIT_SIZE*i +: FLIT_SIZE] = x;
   endtask

   task automatic half();
      @(negedge clk);
      if (bus.out_valid && bus.out_avail) begin
         got_f.push_back(bus.out);
         got_s.push_back(int'(bus.out_src));
      end
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic step(logic [N-1:0] mask, flit_type_t t, int base);
      bus.in_valid = mask;
      for (int i = 0; i < N; i++) set_ch(i, mk(t, base + i));
      half();
      edge_();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid  = '0;
      bus.in        = '0;
      bus.out_avail = 1'b1;
      edge_();
      edge_();
      rst = 1'b0;
      got_f.delete();
      got_s.delete();
   endtask

   task automatic chk_got(string nm, int k, int es, flit_t ef);
      chk($sformatf("%s%0d_src", nm, k), (k < got_s.size()) ? got_s[k] : 32'hx, es);
      chk($sformatf("%s%0d_flit", nm, k), (k < got_f.size()) ? got_f[k] : 16'hx, ef);
   endtask

   task automatic gen_next(int i);
      flit_type_t t;
      int r;
      if (grem[i] > 0) begin
         t = (grem[i] == 1) ? TAIL_FLIT : BODY_FLIT;
         grem[i]--;
      end else begin
         r = $urandom_range(0, 19);
         if (r < 8) t = SINGLE_FLIT;
         else if (r < 18) begin
            t = HEAD_FLIT;
            grem[i] = $urandom_range(1, 4);
         end else t = (r == 18) ? BODY_FLIT : TAIL_FLIT;
      end
      gf[i] = mk(t, $urandom_range(0, (1 << PW) - 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // ---- reset state ----
      rst = 1'b1;
      bus.in_valid  = '0;
      bus.in        = '0;
      bus.out_avail = 1'b1;
      edge_();
      @(negedge clk);
      chk("rst_in_avail", bus.in_avail, 8'h00);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out", bus.out, 0);
      chk("rst_out_src", bus.out_src, 0);
      chk("rst_drop", bus.drop_err, 0);
      edge_();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_avail", bus.in_avail, 8'hFF);
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_out", bus.out, 0);
      chk("post_rst_out_src", bus.out_src, 0);
      edge_();

      // ---- single packet on ch3, then rr_ptr=4 shown by picking ch5 before ch2 ----
      tbl[0] = '{8'h08, HEAD_FLIT,   14'h10, 1'b1, 1'b0, 3'd0, 16'h0,                   1'b0};
      tbl[1] = '{8'h08, BODY_FLIT,   14'h20, 1'b1, 1'b1, 3'd3, mk(HEAD_FLIT, 'h13),     1'b0};
      tbl[2] = '{8'h08, BODY_FLIT,   14'h30, 1'b1, 1'b1, 3'd3, mk(BODY_FLIT, 'h23),     1'b0};
      tbl[3] = '{8'h08, TAIL_FLIT,   14'h40, 1'b1, 1'b1, 3'd3, mk(BODY_FLIT, 'h33),     1'b0};
      tbl[4] = '{8'h00, BODY_FLIT,   14'h00, 1'b1, 1'b1, 3'd3, mk(TAIL_FLIT, 'h43),     1'b0};
      tbl[5] = '{8'h24, SINGLE_FLIT, 14'h50, 1'b1, 1'b0, 3'd0, 16'h0,                   1'b0};
      tbl[6] = '{8'h00, BODY_FLIT,   14'h00, 1'b1, 1'b1, 3'd5, mk(SINGLE_FLIT, 'h55),   1'b0};
      tbl[7] = '{8'h00, BODY_FLIT,   14'h00, 1'b1, 1'b1, 3'd2, mk(SINGLE_FLIT, 'h52),   1'b0};
      tbl[8] = '{8'h00, BODY_FLIT,   14'h00, 1'b1, 1'b0, 3'd0, 16'h0,                   1'b0};
      for (int t = 0; t < 9; t++) begin
         bus.out_avail = tbl[t].oav;
         bus.in_valid  = tbl[t].vmask;
         for (int i = 0; i < N; i++) set_ch(i, mk(tbl[t].typ, int'(tbl[t].base) + i));
         @(negedge clk);
         chk($sformatf("tbl%0d_vld", t), bus.out_valid, tbl[t].evld);
         chk($sformatf("tbl%0d_src", t), bus.out_src, tbl[t].esrc);
         chk($sformatf("tbl%0d_out", t), bus.out, tbl[t].eout);
         chk($sformatf("tbl%0d_drop", t), bus.drop_err, tbl[t].edrop);
         edge_();
      end

      // ---- contention: ch1 and ch5 3-flit packets, same cycle ----
      do_reset();
      step(8'h22, HEAD_FLIT, 'h60);
      step(8'h22, BODY_FLIT, 'h70);
      step(8'h22, TAIL_FLIT, 'h80);
      for (int c = 0; c < 10; c++) step(8'h00, BODY_FLIT, 0);
      chk("cont_count", got_f.size(), 6);
      chk_got("cont", 0, 1, mk(HEAD_FLIT, 'h61));
      chk_got("cont", 1, 1, mk(BODY_FLIT, 'h71));
      chk_got("cont", 2, 1, mk(TAIL_FLIT, 'h81));
      chk_got("cont", 3, 5, mk(HEAD_FLIT, 'h65));
      chk_got("cont", 4, 5, mk(BODY_FLIT, 'h75));
      chk_got("cont", 5, 5, mk(TAIL_FLIT, 'h85));

      // ---- backpressure: 6-flit packet on ch0 into a depth-4 FIFO ----
      do_reset();
      for (int k = 0; k < 6; k++)
         pkt[k] = mk((k == 0) ? HEAD_FLIT : (k == 5) ? TAIL_FLIT : BODY_FLIT, 'hA0 + k);
      ptr = 0;
      bus.out_avail = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid[0] = (ptr < 6);
         set_ch(0, pkt[(ptr < 6) ? ptr : 5]);
         @(negedge clk);
         if (c >= 1) begin
            chk($sformatf("bp_hold%0d_vld", c), bus.out_valid, 1);
            chk($sformatf("bp_hold%0d_out", c), bus.out, pkt[0]);
            chk($sformatf("bp_hold%0d_src", c), bus.out_src, 0);
         end
         if (c == 4) chk("bp_in_avail_full", bus.in_avail[0], 0);
         if (bus.in_valid[0] && bus.in_avail[0]) ptr++;
         edge_();
      end
      chk("bp_pushes", ptr, 4);
      bus.out_avail = 1'b1;
      for (int c = 0; c < 20; c++) begin
         bus.in_valid[0] = (ptr < 6);
         set_ch(0, pkt[(ptr < 6) ? ptr : 5]);
         half();
         if (bus.in_valid[0] && bus.in_avail[0]) ptr++;
         edge_();
      end
      chk("bp_count", got_f.size(), 6);
      for (int k = 0; k < 6; k++) chk_got("bp", k, 0, pkt[k]);

      // ---- round robin: all channels offer SINGLE flits continuously ----
      do_reset();
      for (int c = 0; c < 30 && got_s.size() < 9; c++) step(8'hFF, SINGLE_FLIT, 0);
      chk("rr_count", got_s.size() >= 9, 1);
      for (int k = 0; k < 9; k++)
         chk($sformatf("rr%0d_src", k), (k < got_s.size()) ? got_s[k] : 32'hx, k % N);

      // ---- orphan BODY on ch2 while unlocked ----
      do_reset();
      step(8'h04, BODY_FLIT, 'hB0);
      bus.in_valid = '0;
      half();
      chk("orph_drop", bus.drop_err, 1);
      chk("orph_vld", bus.out_valid, 0);
      edge_();
      bus.in_valid = 8'h04;
      set_ch(2, mk(SINGLE_FLIT, 'hC2));
      half();
      chk("orph_drop_once", bus.drop_err, 0);
      edge_();
      bus.in_valid = '0;
      half();
      chk("orph_empty_vld", bus.out_valid, 1);
      chk("orph_empty_out", bus.out, mk(SINGLE_FLIT, 'hC2));
      chk("orph_empty_src", bus.out_src, 2);
      edge_();

      // ---- locked owner ch0 starves mid-packet while ch6 holds a HEAD ----
      got_f.delete();
      got_s.delete();
      bus.in_valid = 8'h01; set_ch(0, mk(HEAD_FLIT, 'hD0)); half(); edge_();
      bus.in_valid = 8'h41; set_ch(0, mk(BODY_FLIT, 'hD1)); set_ch(6, mk(HEAD_FLIT, 'hE0)); half(); edge_();
      bus.in_valid = 8'h40; set_ch(6, mk(TAIL_FLIT, 'hE1)); half(); edge_();
      bus.in_valid = 8'h00;
      for (int c = 0; c < 2; c++) begin
         half();
         chk($sformatf("stall%0d_vld", c), bus.out_valid, 0);
         chk($sformatf("stall%0d_drop", c), bus.drop_err, 0);
         edge_();
      end
      bus.in_valid = 8'h01; set_ch(0, mk(TAIL_FLIT, 'hD2));
      half();
      chk("stall2_vld", bus.out_valid, 0);
      edge_();
      bus.in_valid = 8'h00;
      for (int c = 0; c < 6; c++) begin
         half();
         edge_();
      end
      chk("stall_count", got_f.size(), 5);
      chk_got("stall", 0, 0, mk(HEAD_FLIT, 'hD0));
      chk_got("stall", 1, 0, mk(BODY_FLIT, 'hD1));
      chk_got("stall", 2, 0, mk(TAIL_FLIT, 'hD2));
      chk_got("stall", 3, 6, mk(HEAD_FLIT, 'hE0));
      chk_got("stall", 4, 6, mk(TAIL_FLIT, 'hE1));

      // ---- random traffic against a queue-level model, with one mid-run reset ----
      do_reset();
      mlock = 1'b0;
      mown  = 0;
      mrr   = 0;
      for (int i = 0; i < N; i++) begin
         mq[i].delete();
         grem[i] = 0;
         gen_next(i);
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = (cyc >= 1500) && (cyc < 1502);
         oav = ($urandom_range(0, 9) < 7);
         bus.out_avail = oav;
         for (int i = 0; i < N; i++) begin
            v[i] = ($urandom_range(0, 9) < 6);
            set_ch(i, gf[i]);
         end
         bus.in_valid = v;
         @(negedge clk);

         ex_vld  = 1'b0;
         ex_src  = 0;
         ex_drop = 1'b0;
         ex_didx = 0;
         ex_av   = '0;
         if (!rst) begin
            for (int i = 0; i < N; i++) ex_av[i] = (mq[i].size() < DEPTH);
            if (!mlock) begin
               for (int k = 0; k < N; k++) begin
                  int j;
                  j = (mrr + k) % N;
                  if (!ex_vld && mq[j].size() > 0 &&
                      (ftype(mq[j][0]) == HEAD_FLIT || ftype(mq[j][0]) == SINGLE_FLIT)) begin
                     ex_vld = 1'b1;
                     ex_src = j;
                  end
               end
            end else if (mq[mown].size() > 0) begin
               ex_vld = 1'b1;
               ex_src = mown;
            end
            for (int j = 0; j < N; j++) begin
               if (!ex_drop && mq[j].size() > 0 && !(mlock && j == mown) &&
                   (ftype(mq[j][0]) == BODY_FLIT || ftype(mq[j][0]) == TAIL_FLIT)) begin
                  ex_drop = 1'b1;
                  ex_didx = j;
               end
            end
         end
         ex_out = ex_vld ? mq[ex_src][0] : '0;

         chk($sformatf("rnd%0d_in_avail", cyc), bus.in_avail, ex_av);
         chk($sformatf("rnd%0d_vld", cyc), bus.out_valid, ex_vld);
         chk($sformatf("rnd%0d_out", cyc), bus.out, ex_out);
         chk($sformatf("rnd%0d_src", cyc), bus.out_src, ex_vld ? ex_src : 0);
         chk($sformatf("rnd%0d_drop", cyc), bus.drop_err, ex_drop);

         if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mlock = 1'b0;
            mown  = 0;
            mrr   = 0;
         end else begin
            if (ex_vld && oav) begin
               f = mq[ex_src].pop_front();
               if (!mlock) begin
                  if (ftype(f) == HEAD_FLIT) begin
                     mlock = 1'b1;
                     mown  = ex_src;
                  end else mrr = (ex_src + 1) % N;
               end else if (ftype(f) != BODY_FLIT) begin
                  mlock = 1'b0;
                  mrr   = (mown + 1) % N;
               end
            end
            if (ex_drop) void'(mq[ex_didx].pop_front());
            for (int i = 0; i < N; i++) begin
               if (v[i] && ex_av[i]) begin
                  mq[i].push_back(gf[i]);
                  gen_next(i);
               end
            end
         end
         edge_();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
